// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline definitions: forward-select encodings, multi-cycle unit
// state encoding and counter sizing.
package fwd_hazard_unit_pkg;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    MC_IDLE = 1'b0,
    MC_BUSY = 1'b1
  } mc_state_e;

  // Wide enough for the largest supported multi-cycle latency (15).
  localparam int MC_CNT_W = 4;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

endpackage

// File: rtl/fwd_hazard_unit_slot_sel.sv
// Forward-source selection for one EX-stage source operand.
module fwd_slot_sel
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic              ex_mem_regwrite,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              mem_wb_regwrite,
  input  logic [REG_AW-1:0] mem_wb_rd,
  output fwd_sel_e          sel
);

  // NOTE: always_comb assigns a default first so no path can infer a latch.
  always_comb begin
    sel = FWD_RF;
    // r0 is hard-wired zero, so a write to it is never a forwarding source.
    if (ex_mem_regwrite && (ex_mem_rd != '0) && (ex_mem_rd == src)) begin
      sel = FWD_EXMEM;
    end else if (mem_wb_regwrite && (mem_wb_rd != '0) && (mem_wb_rd == src)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: per-operand forward selects, load-use /
// scoreboard / structural stall, a multi-cycle unit tracker and stall statistics.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int MC_LAT  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_vld,
  input  logic [NUM_SRC*REG_AW-1:0] ex_src,
  input  logic                      id_ex_memread,
  input  logic [REG_AW-1:0]         id_ex_rd,
  input  logic                      ex_mem_regwrite,
  input  logic [REG_AW-1:0]         ex_mem_rd,
  input  logic                      mem_wb_regwrite,
  input  logic [REG_AW-1:0]         mem_wb_rd,
  input  logic                      mc_start,
  input  logic [REG_AW-1:0]         mc_dest,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic                      stall,
  output logic                      mc_busy,
  output logic                      mc_done,
  output logic [REG_AW-1:0]         mc_wb_rd,
  output logic [15:0]               stall_cnt
);

  localparam logic [MC_CNT_W-1:0] CNT_LOAD = MC_CNT_W'(MC_LAT - 1);
  localparam logic [MC_CNT_W-1:0] CNT_ONE  = MC_CNT_W'(1);

  mc_state_e             state;
  logic [MC_CNT_W-1:0]   mc_cnt;
  logic                  load_use_haz;
  logic                  sb_haz;
  logic                  struct_haz;
  logic                  mc_accept;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_slot
    fwd_sel_e slot_sel;

    fwd_slot_sel #(
      .REG_AW(REG_AW)
    ) u_fwd_slot_sel (
      .src             (ex_src[k*REG_AW +: REG_AW]),
      .ex_mem_regwrite (ex_mem_regwrite),
      .ex_mem_rd       (ex_mem_rd),
      .mem_wb_regwrite (mem_wb_regwrite),
      .mem_wb_rd       (mem_wb_rd),
      .sel             (slot_sel)
    );

    assign fwd_sel[k*2 +: 2] = slot_sel;
  end

  // mc_busy is held low through reset, which also masks the scoreboard term.
  always_comb begin
    load_use_haz = 1'b0;
    sb_haz       = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (id_src_vld[k]) begin
        if (id_ex_memread && (id_ex_rd != '0) &&
            (id_ex_rd == id_src[k*REG_AW +: REG_AW])) begin
          load_use_haz = 1'b1;
        end
        if (mc_busy && (mc_wb_rd != '0) &&
            (mc_wb_rd == id_src[k*REG_AW +: REG_AW])) begin
          sb_haz = 1'b1;
        end
      end
    end
  end

  assign struct_haz = mc_start & mc_busy;
  assign stall      = load_use_haz | sb_haz | struct_haz;
  assign mc_accept  = mc_start & ~mc_busy & ~stall;

  // The done cycle is spent in IDLE with mc_busy low, so a new start can be
  // taken in that same cycle.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= MC_IDLE;
      mc_busy  <= 1'b0;
      mc_done  <= 1'b0;
      mc_wb_rd <= '0;
      mc_cnt   <= '0;
    end else begin
      mc_done <= 1'b0;
      case (state)
        MC_IDLE: begin
          if (mc_accept) begin
            state    <= MC_BUSY;
            mc_busy  <= 1'b1;
            mc_wb_rd <= mc_dest;
            mc_cnt   <= CNT_LOAD;
          end
        end
        MC_BUSY: begin
          mc_cnt <= mc_cnt - CNT_ONE;
          if (mc_cnt == CNT_ONE) begin
            state   <= MC_IDLE;
            mc_busy <= 1'b0;
            mc_done <= 1'b1;
          end
        end
        default: begin
          state   <= MC_IDLE;
          mc_busy <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != STALL_CNT_MAX)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus randomized
// traffic compared against a timestamp-based behavioural model.
module tb_fwd_hazard_unit;

  localparam int REG_AW  = 5;
  localparam int NUM_SRC = 2;
  localparam int MC_LAT  = 4;

  logic                      clk;
  logic                      rst;
  logic [NUM_SRC*REG_AW-1:0] id_src;
  logic [NUM_SRC-1:0]        id_src_vld;
  logic [NUM_SRC*REG_AW-1:0] ex_src;
  logic                      id_ex_memread;
  logic [REG_AW-1:0]         id_ex_rd;
  logic                      ex_mem_regwrite;
  logic [REG_AW-1:0]         ex_mem_rd;
  logic                      mem_wb_regwrite;
  logic [REG_AW-1:0]         mem_wb_rd;
  logic                      mc_start;
  logic [REG_AW-1:0]         mc_dest;
  logic [NUM_SRC*2-1:0]      fwd_sel;
  logic                      stall;
  logic                      mc_busy;
  logic                      mc_done;
  logic [REG_AW-1:0]         mc_wb_rd;
  logic [15:0]               stall_cnt;

  fwd_hazard_unit #(
    .REG_AW (REG_AW),
    .NUM_SRC(NUM_SRC),
    .MC_LAT (MC_LAT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_src          (id_src),
    .id_src_vld      (id_src_vld),
    .ex_src          (ex_src),
    .id_ex_memread   (id_ex_memread),
    .id_ex_rd        (id_ex_rd),
    .ex_mem_regwrite (ex_mem_regwrite),
    .ex_mem_rd       (ex_mem_rd),
    .mem_wb_regwrite (mem_wb_regwrite),
    .mem_wb_rd       (mem_wb_rd),
    .mc_start        (mc_start),
    .mc_dest         (mc_dest),
    .fwd_sel         (fwd_sel),
    .stall           (stall),
    .mc_busy         (mc_busy),
    .mc_done         (mc_done),
    .mc_wb_rd        (mc_wb_rd),
    .stall_cnt       (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: an operation is described by the cycle it was accepted in; busy
  // and done are derived from the distance to that cycle.
  int       cyc       = 0;
  bit       op_valid  = 1'b0;
  int       op_start  = 0;
  int       m_rd      = 0;
  int       m_cnt     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit model_busy();
    return op_valid && (cyc > op_start) && (cyc < op_start + MC_LAT);
  endfunction

  function automatic bit model_done();
    return op_valid && (cyc == op_start + MC_LAT);
  endfunction

  function automatic int exp_fwd(input int k);
    int s;
    s = int'(ex_src[k*REG_AW +: REG_AW]);
    if (ex_mem_regwrite && int'(ex_mem_rd) != 0 && int'(ex_mem_rd) == s) return 1;
    if (mem_wb_regwrite && int'(mem_wb_rd) != 0 && int'(mem_wb_rd) == s) return 2;
    return 0;
  endfunction

  function automatic bit exp_stall();
    bit h;
    int s;
    h = mc_start && model_busy();
    for (int k = 0; k < NUM_SRC; k++) begin
      s = int'(id_src[k*REG_AW +: REG_AW]);
      if (id_src_vld[k]) begin
        if (id_ex_memread && int'(id_ex_rd) != 0 && int'(id_ex_rd) == s) h = 1'b1;
        if (model_busy() && m_rd != 0 && m_rd == s) h = 1'b1;
      end
    end
    return h;
  endfunction

  task automatic model_reset();
    op_valid = 1'b0;
    m_rd     = 0;
    m_cnt    = 0;
  endtask

  // Compare all outputs on the falling edge, then advance the model over the
  // rising edge and return just after it.
  task automatic step(input bit do_chk);
    bit st;
    @(negedge clk);
    st = exp_stall();
    if (do_chk) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        check($sformatf("fwd_sel[%0d]", k), 32'(fwd_sel[k*2 +: 2]), 32'(exp_fwd(k)));
      end
      check("stall", 32'(stall), 32'(st));
      check("mc_busy", 32'(mc_busy), 32'(model_busy()));
      check("mc_done", 32'(mc_done), 32'(model_done()));
      check("mc_wb_rd", 32'(mc_wb_rd), 32'(m_rd));
      check("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
    end
    @(posedge clk);
    if (!rst) begin
      if (st && m_cnt < 65535) m_cnt++;
      if (mc_start && !model_busy() && !st) begin
        op_valid = 1'b1;
        op_start = cyc;
        m_rd     = int'(mc_dest);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    id_src = '0; id_src_vld = '0; ex_src = '0;
    id_ex_memread = 1'b0; id_ex_rd = '0;
    ex_mem_regwrite = 1'b0; ex_mem_rd = '0;
    mem_wb_regwrite = 1'b0; mem_wb_rd = '0;
    mc_start = 1'b0; mc_dest = '0;
  endtask

  initial begin
    int prev;
    rst = 1'b1;
    idle_inputs();
    model_reset();

    // Reset state.
    step(1'b1);
    step(1'b1);
    check("rst_busy", 32'(mc_busy), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);
    rst = 1'b0;
    step(1'b1);

    // EX/MEM has priority over MEM/WB for the same register.
    ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd5;
    mem_wb_regwrite = 1'b1; mem_wb_rd = 5'd5;
    ex_src = {5'd0, 5'd5};
    #1 check("fwd_prio", 32'(fwd_sel[1:0]), 32'd1);
    step(1'b1);

    // Register 0 is never forwarded.
    ex_mem_regwrite = 1'b1; ex_mem_rd = 5'd0;
    mem_wb_regwrite = 1'b0; mem_wb_rd = 5'd0;
    ex_src = '0;
    #1 check("fwd_r0", 32'(fwd_sel), 32'd0);
    step(1'b1);
    idle_inputs();

    // Load-use on slot 1, then the same index on an unused slot.
    id_ex_memread = 1'b1; id_ex_rd = 5'd7;
    id_src = {5'd7, 5'd0}; id_src_vld = 2'b10;
    prev = m_cnt;
    #1 check("lu_stall", 32'(stall), 32'd1);
    step(1'b1);
    check("lu_cnt_inc", 32'(stall_cnt), 32'(prev + 1));
    id_src_vld = 2'b01;
    #1 check("lu_unused", 32'(stall), 32'd0);
    step(1'b1);
    idle_inputs();

    // Scoreboard: op to r9, ID reads r9.
    id_src = {5'd0, 5'd9}; id_src_vld = 2'b01;
    mc_start = 1'b1; mc_dest = 5'd9;
    #1 check("sb_c0_stall", 32'(stall), 32'd0);
    step(1'b1);
    mc_start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      check($sformatf("sb_c%0d_stall", c), 32'(stall), 32'd1);
      check($sformatf("sb_c%0d_done", c), 32'(mc_done), 32'd0);
      step(1'b1);
    end
    check("sb_c4_done", 32'(mc_done), 32'd1);
    check("sb_c4_stall", 32'(stall), 32'd0);
    check("sb_c4_rd", 32'(mc_wb_rd), 32'd9);
    step(1'b1);
    check("sb_c5_done", 32'(mc_done), 32'd0);
    idle_inputs();
    step(1'b1);

    // Structural hazard, then back-to-back acceptance in the done cycle.
    mc_start = 1'b1; mc_dest = 5'd3;
    step(1'b1);
    mc_dest = 5'd12;
    check("st_stall", 32'(stall), 32'd1);
    step(1'b1);
    step(1'b1);
    check("st_rd_kept", 32'(mc_wb_rd), 32'd3);
    step(1'b1);
    check("b2b_done", 32'(mc_done), 32'd1);
    check("b2b_stall", 32'(stall), 32'd0);
    step(1'b1);
    check("b2b_busy", 32'(mc_busy), 32'd1);
    check("b2b_rd", 32'(mc_wb_rd), 32'd12);
    mc_start = 1'b0;
    repeat (5) step(1'b1);

    // Reset in cycle 2 of an operation aborts it without a done pulse.
    mc_start = 1'b1; mc_dest = 5'd20;
    step(1'b1);
    mc_start = 1'b0;
    step(1'b1);
    rst = 1'b1;
    model_reset();
    #1;
    check("abort_busy", 32'(mc_busy), 32'd0);
    check("abort_rd", 32'(mc_wb_rd), 32'd0);
    step(1'b1);
    rst = 1'b0;
    repeat (6) begin
      step(1'b1);
      check("abort_no_done", 32'(mc_done), 32'd0);
    end

    // Randomized traffic over a small register range to provoke matches.
    repeat (400) begin
      id_src          = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_src_vld      = 2'($urandom);
      ex_src          = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_ex_memread   = ($urandom_range(0, 3) == 0);
      id_ex_rd        = 5'($urandom_range(0, 7));
      ex_mem_regwrite = 1'($urandom);
      ex_mem_rd       = 5'($urandom_range(0, 7));
      mem_wb_regwrite = 1'($urandom);
      mem_wb_rd       = 5'($urandom_range(0, 7));
      mc_start        = ($urandom_range(0, 3) == 0);
      mc_dest         = 5'($urandom_range(0, 7));
      step(1'b1);
    end
    idle_inputs();
    repeat (MC_LAT + 1) step(1'b1);

    // Saturation of the stall counter.
    id_ex_memread = 1'b1; id_ex_rd = 5'd7;
    id_src = {5'd7, 5'd0}; id_src_vld = 2'b10;
    repeat (65540) step(1'b0);
    step(1'b1);
    check("sat_cnt", 32'(stall_cnt), 32'hFFFF);
    step(1'b1);
    check("sat_hold", 32'(stall_cnt), 32'hFFFF);
    idle_inputs();
    step(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 The block SHALL have parameter REG_AW, default 5, meaning register-index width.
REQ-002 The block SHALL have parameter NUM_SRC, default 2, meaning source operands per instruction (range 1..4).
REQ-003 The block SHALL have parameter MC_LAT, default 4, meaning multi-cycle unit latency in cycles (range 2..15).
REQ-004 The block SHALL have a single clock and an asynchronous, active-high reset; all state SHALL be clocked on the rising edge of clk.
REQ-005 The block SHALL have port clk, input, width 1: the clock.
REQ-006 The block SHALL have port rst, input, width 1: asynchronous active-high reset.
REQ-007 The block SHALL have port id_src, input, width NUM_SRC*REG_AW: ID-stage source indices, where slot k is bits [k*REG_AW +: REG_AW].
REQ-008 The block SHALL have port id_src_vld, input, width NUM_SRC: per-slot "operand used" flags.
REQ-009 The block SHALL have port ex_src, input, width NUM_SRC*REG_AW: ID/EX-stage source indices.
REQ-010 The block SHALL have ports id_ex_memread (width 1) and id_ex_rd (width REG_AW), inputs: identify a load currently in EX.
REQ-011 The block SHALL have ports ex_mem_regwrite (width 1), ex_mem_rd (width REG_AW), mem_wb_regwrite (width 1) and mem_wb_rd (width REG_AW), inputs: the later-stage writers.
REQ-012 The block SHALL have ports mc_start (width 1) and mc_dest (width REG_AW), inputs: a multi-cycle op issue request and its destination.
REQ-013 The block SHALL have port fwd_sel, output, width NUM_SRC*2: per-slot forward select.
REQ-014 The block SHALL have port stall, output, width 1: hold PC and IF/ID, and insert a bubble into ID/EX.
REQ-015 The block SHALL have ports mc_busy (width 1), mc_done (width 1) and mc_wb_rd (width REG_AW), outputs: multi-cycle unit status.
REQ-016 The block SHALL have port stall_cnt, output, width 16: saturating count of stalled cycles.

Function
REQ-017 fwd_sel slot k SHALL be 2'b01 when ex_mem_regwrite is high, ex_mem_rd != 0 and ex_mem_rd == ex_src[k]; otherwise 2'b10 when the same conditions hold for mem_wb; otherwise 2'b00; fwd_sel is combinational with no latency, and EX/MEM has priority.
REQ-018 fwd_sel SHALL never select a forwarding source for register index 0.
REQ-019 Load-use hazard SHALL be asserted when id_ex_memread is high, id_ex_rd != 0, and id_ex_rd == id_src[k] for any k with id_src_vld[k] set.
REQ-020 Scoreboard hazard SHALL be asserted when mc_busy is high, mc_wb_rd != 0, and mc_wb_rd == id_src[k] for any valid k.
REQ-021 Structural hazard SHALL be asserted when mc_start is high while mc_busy is high.
REQ-022 stall SHALL be the combinational OR of the load-use, scoreboard and structural hazards.
REQ-023 mc_start SHALL be accepted only when mc_busy is low and stall is low.
REQ-024 On an accepted mc_start, the block SHALL register mc_dest into mc_wb_rd, set mc_busy, and load the down-counter with MC_LAT-1.
REQ-025 The state machine SHALL have two states, IDLE and BUSY: IDLE to BUSY on an accepted start; BUSY decrements the counter each cycle.
REQ-026 When the counter reaches 0 in BUSY, the block SHALL return to IDLE and pulse mc_done for exactly one cycle, with mc_wb_rd still valid during that cycle.
REQ-027 In the mc_done cycle, mc_busy SHALL already be low, so the scoreboard hazard clears and the result is forwarded by the pipeline through the normal path.
REQ-028 A start accepted exactly in the mc_done cycle SHALL be legal, giving back-to-back operations with no idle gap.
REQ-029 An mc_start rejected for structural reasons SHALL be dropped; the requester SHALL hold it, since the asserted stall keeps the instruction in ID.
REQ-030 stall_cnt SHALL increment on every cycle in which stall is high, and saturate at 16'hFFFF without wrapping.
REQ-031 An mc_dest of 0 SHALL still occupy the unit for MC_LAT cycles, but SHALL never cause a scoreboard hazard.

Reset
REQ-032 Assertion of rst SHALL asynchronously clear the state to IDLE and force mc_busy=0, mc_done=0, mc_wb_rd=0, counter=0 and stall_cnt=0.
REQ-033 Reset asserted mid-operation SHALL abort the pending multi-cycle op, and no mc_done SHALL be emitted for it.
REQ-034 During reset, fwd_sel and stall SHALL follow their combinational inputs, with the scoreboard term forced low.

Structure
REQ-035 The fwd_sel encodings (FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10) and the state encoding SHALL live in the shared pipeline package.
REQ-036 Per-slot forward logic SHALL be instantiated NUM_SRC times as sub-module fwd_slot_sel; the scoreboard, counter and stall statistics SHALL stay in the top-level block.

Verification
REQ-037 The bench SHALL drive ex_mem_regwrite=1, ex_mem_rd=5, mem_wb_regwrite=1, mem_wb_rd=5, ex_src slot0=5, and check fwd_sel slot0=01 (EX/MEM priority).
REQ-038 The bench SHALL drive ex_mem_rd=0 with regwrite=1 and ex_src=0, and check fwd_sel=00.
REQ-039 The bench SHALL drive id_ex_memread=1, id_ex_rd=7, id_src slot1=7, id_src_vld=2'b10, and check stall=1 and stall_cnt +1; with id_src_vld=2'b01 it SHALL check stall=0.
REQ-040 With MC_LAT=4, the bench SHALL drive mc_start with mc_dest=9 at cycle 0 and an ID source of 9, and check stall high in cycles 1-3, mc_done high in cycle 4 only, stall low in cycle 4, and mc_wb_rd=9.
REQ-041 The bench SHALL drive mc_start on a busy unit and check stall=1 and that the second start is not accepted; on re-asserting start in the mc_done cycle, it SHALL check acceptance with mc_busy high the next cycle.
REQ-042 The bench SHALL assert rst at cycle 2 of a BUSY op and check mc_busy=0 and no mc_done pulse; it SHALL also force 65535 stall cycles and check that stall_cnt holds at 16'hFFFF.
